// File: rtl/exe_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : exe_muldiv_if
// Brief    : Execute-stage handshake bundle between the pipeline and the
//            iterative multiply/divide unit.
// Revision : 1.0
// ============================================================================
interface exe_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [4:0]      rd_i;
    logic            flush;
    logic            hold_req;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_o;

    modport master (
        output start, funct3, data1, data2, rd_i, flush,
        input  hold_req, busy, result_valid, result, rd_o
    );

    modport slave (
        input  start, funct3, data1, data2, rd_i, flush,
        output hold_req, busy, result_valid, result, rd_o
    );
endinterface
`default_nettype wire

// File: rtl/exe_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : exe_muldiv
// Brief    : Iterative RV32M multiply/divide unit (shift-add multiply,
//            restoring divide). Define EXE_MULDIV_FAST_MUL_EN for a
//            single-cycle multiplier path.
// Revision : 1.0
// ============================================================================
module exe_muldiv #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    exe_muldiv_if.slave  bus
);
    localparam int              c_acc_w = 2 * XLEN;
    localparam logic [5:0]      c_last  = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] c_min   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_hold;
    logic [5:0]           r_cnt;
    logic [2:0]           r_op;
    logic [4:0]           r_rd;
    logic                 r_neg;
    logic [c_acc_w-1:0]   r_acc;
    logic [XLEN-1:0]      r_mcand;
    logic                 r_busy;
    logic                 r_valid;
    logic [XLEN-1:0]      r_result;
    logic [4:0]           r_rd_o;

    // Operand decode in IDLE
    logic            w_is_div;
    logic            w_sign1;
    logic            w_sign2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_accept;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    logic            w_direct;
    logic [XLEN-1:0] w_direct_res;

    assign w_is_div = bus.funct3[2];
    assign w_sign1  = (bus.funct3 inside {3'd1, 3'd2, 3'd4, 3'd6}) & bus.data1[XLEN-1];
    assign w_sign2  = (bus.funct3 inside {3'd1, 3'd4, 3'd6}) & bus.data2[XLEN-1];
    assign w_mag1   = w_sign1 ? -bus.data1 : bus.data1;
    assign w_mag2   = w_sign2 ? -bus.data2 : bus.data2;
    assign w_accept = bus.start & ~bus.flush;

    assign w_div_zero    = w_is_div & (bus.data2 == '0);
    assign w_ovf         = w_is_div & ~bus.funct3[0] & (bus.data1 == c_min) & (bus.data2 == '1);
    assign w_special     = w_div_zero | w_ovf;
    assign w_special_res = w_div_zero ? (bus.funct3[1] ? bus.data1 : '1)
                                      : (bus.funct3[1] ? '0 : c_min);

`ifdef EXE_MULDIV_FAST_MUL_EN
    // Sign-extended 64-bit product equals the 33x33 signed product mod 2^64
    logic [c_acc_w-1:0] w_fast_prod;
    assign w_fast_prod = $signed({{XLEN{w_sign1}}, bus.data1}) *
                         $signed({{XLEN{w_sign2}}, bus.data2});
    assign w_fast      = ~w_is_div;
    assign w_fast_res  = (bus.funct3[1:0] == 2'd0) ? w_fast_prod[XLEN-1:0]
                                                   : w_fast_prod[c_acc_w-1:XLEN];
`else
    assign w_fast      = 1'b0;
    assign w_fast_res  = '0;
`endif

    assign w_direct     = w_special | w_fast;
    assign w_direct_res = w_special ? w_special_res : w_fast_res;

    // One iteration of shift-add multiply or restoring divide
    logic [XLEN:0]        w_mul_sum;
    logic [c_acc_w-1:0]   w_mul_step;
    logic [XLEN:0]        w_div_part;
    logic [XLEN:0]        w_div_diff;
    logic                 w_div_ge;
    logic [c_acc_w-1:0]   w_div_step;

    assign w_mul_sum  = {1'b0, r_acc[c_acc_w-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_div_part = {r_acc[c_acc_w-1:XLEN], r_acc[XLEN-1]};
    assign w_div_diff = w_div_part - {1'b0, r_mcand};
    assign w_div_ge   = ~w_div_diff[XLEN];
    assign w_div_step = {(w_div_ge ? w_div_diff[XLEN-1:0] : w_div_part[XLEN-1:0]),
                         r_acc[XLEN-2:0], w_div_ge};

    logic [c_acc_w-1:0] w_prod;
    logic [XLEN-1:0]    w_quo;
    logic [XLEN-1:0]    w_rem;
    logic [XLEN-1:0]    w_fix_res;

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg ? -r_acc[c_acc_w-1:XLEN] : r_acc[c_acc_w-1:XLEN];

    always_comb begin
        w_fix_res = w_rem;
        case (r_op)
            3'd0:                w_fix_res = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    w_fix_res = w_prod[c_acc_w-1:XLEN];
            3'd4, 3'd5:          w_fix_res = w_quo;
            default:             w_fix_res = w_rem;
        endcase
    end

    always_comb begin
        w_next = r_state;
        w_hold = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_hold = 1'b1;
                    w_next = w_direct ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                w_hold = 1'b1;
                if (r_cnt == c_last) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_hold = 1'b1;
                w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.flush) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd_o   <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_valid <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= bus.funct3;
                        r_rd    <= bus.rd_i;
                        // Remainder takes the dividend's sign; everything else the XOR
                        r_neg   <= (bus.funct3[2] & bus.funct3[1]) ? w_sign1 : (w_sign1 ^ w_sign2);
                        r_cnt   <= '0;
                        r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
                        r_mcand <= w_is_div ? w_mag2 : w_mag1;
                        if (w_direct) begin
                            r_result <= w_direct_res;
                            r_rd_o   <= bus.rd_i;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= r_op[2] ? w_div_step : w_mul_step;
                    r_cnt <= r_cnt + 6'd1;
                end
                S_FIX: begin
                    if (!bus.flush) begin
                        r_result <= w_fix_res;
                        r_rd_o   <= r_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hold_req     = w_hold;
    assign bus.busy         = r_busy;
    assign bus.result_valid = r_valid;
    assign bus.result       = r_result;
    assign bus.rd_o         = r_rd_o;
endmodule
`default_nettype wire

// File: tb/tb_exe_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_muldiv
// Brief    : Scoreboard bench for exe_muldiv with directed RV32M vectors.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_exe_muldiv;
`ifdef EXE_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;
    localparam int SPC_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exe_muldiv_if #(.XLEN(32)) bus();
    exe_muldiv #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops an expectation for every result_valid pulse
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got result %h rd %0d at cycle %0d, expected no pulse",
                         bus.result, bus.rd_o, cyc);
            end else begin
                e = sb.pop_front();
                chk({e.nm, " result"}, bus.result, e.res);
                chk({e.nm, " rd_o"}, {27'b0, bus.rd_o}, {27'b0, e.rd});
                chk({e.nm, " valid_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat,
                         input string nm);
        bus.funct3 = f3;
        bus.data1  = a;
        bus.data2  = b;
        bus.rd_i   = rd;
        bus.start  = 1'b1;
        sb.push_back('{exp, rd, cyc + lat, nm});
        #1;
        chk({nm, " hold_c0"}, {31'b0, bus.hold_req}, 32'd1);
    endtask

    task automatic wait_done(input int lat, input string nm);
        int h;
        bit done;
        h    = 0;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.hold_req === 1'b1) h++;
            #1;
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: got no result_valid in 200 cycles, expected one", nm);
            sb.delete();
        end else begin
            chk({nm, " hold_cycles"}, 32'(h), 32'(lat));
        end
    endtask

    task automatic finish_op(input int lat, input string nm);
        fork
            begin
                tick();
                bus.start = 1'b0;
            end
            wait_done(lat, nm);
        join
    endtask

    task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat,
                       input string nm);
        tick();
        issue(f3, a, b, rd, exp, lat, nm);
        finish_op(lat, nm);
        last_res = exp;
        last_rd  = rd;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        int          c0;
        logic [2:0]  rf3;
        logic [31:0] rexp;

        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.data1  = '0;
        bus.data2  = '0;
        bus.rd_i   = '0;
        rst        = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset busy", {31'b0, bus.busy}, 32'd0);
        chk("reset valid", {31'b0, bus.result_valid}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset rd_o", {27'b0, bus.rd_o}, 32'd0);
        chk("reset hold", {31'b0, bus.hold_req}, 32'd0);

        run(3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT, "mul");
        run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, MUL_LAT, "mulh");
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, MUL_LAT, "mulhu");
        run(3'd2, 32'hFFFF_FFFF, 32'd2,        5'd8,  32'hFFFF_FFFF, MUL_LAT, "mulhsu");
        run(3'd4, 32'hFFFF_FFF9, 32'd2,        5'd9,  32'hFFFF_FFFD, DIV_LAT, "div");
        run(3'd6, 32'hFFFF_FFF9, 32'd2,        5'd10, 32'hFFFF_FFFF, DIV_LAT, "rem");
        run(3'd5, 32'd100,      32'd7,         5'd11, 32'd14,        DIV_LAT, "divu");
        run(3'd7, 32'd100,      32'd7,         5'd12, 32'd2,         DIV_LAT, "remu");
        run(3'd4, 32'd5,        32'd0,         5'd13, 32'hFFFF_FFFF, SPC_LAT, "div_by0");
        run(3'd6, 32'd5,        32'd0,         5'd14, 32'd5,         SPC_LAT, "rem_by0");
        run(3'd5, 32'd5,        32'd0,         5'd15, 32'hFFFF_FFFF, SPC_LAT, "divu_by0");
        run(3'd7, 32'd5,        32'd0,         5'd16, 32'd5,         SPC_LAT, "remu_by0");
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, SPC_LAT, "div_ovf");
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0,        SPC_LAT, "rem_ovf");

        // start held through the operation with operands changing underneath
        tick();
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'hFFFF_FFFE, MUL_LAT, "mulhu_held");
        fork
            begin
                tick();
                bus.funct3 = 3'd0;
                bus.data1  = 32'd2;
                bus.data2  = 32'd3;
                repeat (MUL_LAT - 1) tick();
                bus.start = 1'b0;
            end
            wait_done(MUL_LAT, "mulhu_held");
        join
        last_res = 32'hFFFF_FFFE;
        last_rd  = 5'd19;

        // flush in cycle 10 of a DIV, then a fresh start in cycle 11
        tick();
        bus.funct3 = 3'd4;
        bus.data1  = 32'hFFFF_FFF9;
        bus.data2  = 32'd2;
        bus.rd_i   = 5'd3;
        bus.start  = 1'b1;
        c0 = cyc;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        chk("flush busy_c10", {31'b0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        chk("flush cycle_idx", 32'(cyc - c0), 32'd11);
        chk("flush hold_c11", {31'b0, bus.hold_req}, 32'd0);
        chk("flush busy_c11", {31'b0, bus.busy}, 32'd0);
        chk("flush result_held", bus.result, last_res);
        chk("flush rd_held", {27'b0, bus.rd_o}, {27'b0, last_rd});
        issue(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, DIV_LAT, "divu_after_flush");
        finish_op(DIV_LAT, "divu_after_flush");

        // reset in cycle 20 with start held; held start restarts in cycle 21
`ifdef EXE_MULDIV_FAST_MUL_EN
        rf3  = 3'd5;
        rexp = 32'h1555_5555;
`else
        rf3  = 3'd3;
        rexp = 32'd3;
`endif
        tick();
        bus.funct3 = rf3;
        bus.data1  = 32'hFFFF_FFFF;
        bus.data2  = 32'hFFFF_FFFF;
        bus.rd_i   = 5'd12;
        bus.start  = 1'b1;
        repeat (10) tick();
        bus.data1 = 32'h8000_0000;
        bus.data2 = 32'd6;
        repeat (10) tick();
        chk("rst hold_c20", {31'b0, bus.hold_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst result", bus.result, 32'd0);
        chk("rst rd_o", {27'b0, bus.rd_o}, 32'd0);
        chk("rst valid", {31'b0, bus.result_valid}, 32'd0);
        chk("rst busy", {31'b0, bus.busy}, 32'd0);
        chk("rst hold_c21", {31'b0, bus.hold_req}, 32'd1);
        sb.push_back('{rexp, 5'd12, cyc + DIV_LAT, "rst_restart"});
        finish_op(DIV_LAT, "rst_restart");

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/exe_muldiv.md
# exe_muldiv

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EXE pipeline register. It consumes the registered operands (`data1`, `data2`) and the M-extension funct3. It raises `hold_req` to stall the upstream stages for the duration of a multi-cycle operation, then presents a one-cycle `result_valid` with `rd_o` for write-back. Division-by-zero and signed-overflow cases follow the RISC-V spec and complete early.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: operation request from the EXE decode; sampled only in IDLE.
- `funct3` input 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `data1` input 32: rs1 value (dividend / multiplicand).
- `data2` input 32: rs2 value (divisor / multiplier).
- `rd_i` input 5: destination register.
- `flush` input 1: kill the in-flight operation (branch/exception flush).
- `hold_req` output 1: combinational stall request to the pipeline `hold_en`.
- `busy` output 1: registered; high in any state other than IDLE.
- `result_valid` output 1: registered one-cycle pulse.
- `result` output 32: registered result; stable until the next DONE.
- `rd_o` output 5: registered destination; qualifies `result`.

## Operation
- States:
  - IDLE
  - CALC: 32 iterations, 6-bit counter 0..31.
  - FIX: sign correction and result select.
  - DONE: `result_valid`=1.
- IDLE, with `start` and no `flush`:
  - Latch `funct3` and `rd_i`.
  - Latch operand magnitudes: abs for signed operands, where MULHSU treats only `data1` as signed.
  - Latch `neg_res` = sign1^sign2 for product/quotient, or sign1 for remainder.
- Special cases go IDLE->DONE directly, no CALC:
  - DIV/DIVU by zero: quotient 0xFFFFFFFF.
  - REM/REMU by zero: remainder = `data1`.
  - DIV with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000.
  - REM with the same operands: remainder 0.
- Multiply, in CALC:
  - Shift-add over a 64-bit accumulator.
  - Each cycle adds the multiplicand if the multiplier LSB is 1, then shifts right.
  - FIX negates the 64-bit product if `neg_res`.
  - MUL selects [31:0]; MULH/MULHSU/MULHU select [63:32].
- Divide, in CALC:
  - Restoring divide, one quotient bit per cycle.
  - 33-bit partial remainder, compare-subtract.
  - FIX negates the quotient or remainder per `neg_res`.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
- DONE -> IDLE unconditionally. A `start` during DONE is ignored; the pipeline re-presents it.
- `start` in CALC/FIX/DONE: ignored; operands are not re-latched.
- `flush`, any state: next state IDLE, no `result_valid`; `result` and `rd_o` hold their old values. `flush` has priority over `start`.
- `rst`: state IDLE, counter 0, `busy`=0, `result_valid`=0, `result`=0, `rd_o`=0, accumulators 0.
- `hold_req` = (IDLE & `start` & !`flush`) | CALC | FIX.
  - Low in DONE, so the pipeline advances while the result is valid.

## Timing
- `start` in cycle 0:
  - CALC in cycles 1-32.
  - FIX in cycle 33.
  - `result_valid` in cycle 34; IDLE in cycle 35.
- Special-case operations: `result_valid` in cycle 1.
- `hold_req` is high in cycles 0-33 (cycle 0 only for a special case). Upstream stalls exactly until the result appears.
- Back-to-back: the earliest next accepted `start` is the cycle after DONE.
- Reset asserted mid-CALC: IDLE on the next edge, `hold_req` low from then on.

## Configuration
- `EXE_MULDIV_FAST_MUL_EN`, when defined:
  - All four MUL ops use a single-cycle 33x33 signed product, operands sign- or zero-extended per funct3.
  - Path is IDLE->DONE, `result_valid` in cycle 1.
  - `hold_req` is high in cycle 0 only.
- When undefined: multiply uses the 32-cycle CALC path, latency 34.
- Divide behaviour is identical either way.

## Test plan
- MUL 7 x -3, rd=5 -> `result` 0xFFFFFFEB, `rd_o`=5, `result_valid` in cycle 34 (cycle 1 with the macro), `hold_req` high in cycles 0-33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each with `result_valid` in cycle 34.
- DIV 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0. All with `result_valid` in cycle 1.
- `flush` in cycle 10 of a DIV -> IDLE in cycle 11, no `result_valid`, `hold_req` low from cycle 11; a new `start` in cycle 11 completes normally.
- `rst` in cycle 20 of a MULHU, with `start` held high throughout -> all outputs 0 in cycle 21. Cycle 21 is IDLE, so the held `start` is accepted as a fresh operation; a `start` asserted during CALC never re-latches operands.
